trigger_router: RTL and testbench
=================================

# trigger_router

Parametrised successor to the fixed five-source trigger switch. The block routes any of `NSRC` trigger sources to any of `NDST` sinks, such as the soft TBM, the sync output and the direct ROC output. Each sink resolves collisions to a single command per slot, enforces a programmable TRG deadtime, and keeps saturating accepted and dropped trigger counters. It sits between the trigger sources (async, sync, single, generator, pattern generator) and the TBM/ROC output stages. All state advances on the `sync` slot enable.

## Interface
Parameters:
- `NSRC`, 5, number of trigger sources
- `NDST`, 3, number of sinks
- `DT_W`, 8, deadtime counter width
- `CNT_W`, 32, statistics counter width

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-low reset
- `sync`  in  1  slot enable; all state updates only when `sync`=1
- `src_data`  in  `NSRC*5`  source s occupies bits [5s+4:5s], bit order SYN, TRG, RSR, RST, CAL (bit 0..4)
- `sel`  in  `NDST*NSRC`  routing matrix; bit `d*NSRC+s` enables source s to sink d
- `sel_load`  in  1  strobe; copies `sel` into the active matrix
- `deadtime`  in  `DT_W`  TRG deadtime in slots, shared by all sinks
- `cnt_clear`  in  1  clears all statistics counters
- `cnt_idx`  in  `$clog2(NDST)` (min 1)  sink index for the counter readout
- `dst_data`  out  `NDST*5`  registered sink commands, same bit order as `src_data`
- `cnt_trg`  out  `CNT_W`  accepted-TRG count of sink `cnt_idx`
- `cnt_drop`  out  `CNT_W`  dropped-command count of sink `cnt_idx`

## Operation
- **Active matrix**
  - Held in a register; reset value is all zeros, so nothing is routed.
  - Reloaded from `sel` on `sel_load`=1, independent of `sync`.
- **Per-sink OR** (slot with `sync`=1): `raw[d]` = OR over s of (`src_data`[s] AND active bit (d,s)).
- **Priority resolve**
  - Priority order: RST > RSR > CAL > TRG > SYN.
  - Only the highest set bit is forwarded.
  - Each suppressed set bit increments `drop` by 1, i.e. `drop` += popcount(`raw`) − 1 when `raw`≠0.
- **Deadtime** (per-sink counter `dt[d]`)
  - A forwarded TRG with `dt[d]`=0 is output and loads `dt[d]` with `deadtime`.
  - A TRG with `dt[d]`≠0 is dropped: output zero, `drop`+1. A lower-priority SYN does not replace it.
  - A forwarded RST or RSR clears `dt[d]` to 0 in the same slot.
  - Otherwise `dt[d]` decrements by 1 per slot while nonzero.
  - `deadtime`=0 disables suppression.
  - Result: after an accepted TRG in slot t, the next accepted TRG is in slot t+`deadtime`+1 at the earliest.
- **Counters**
  - `trg` increments on each TRG actually output; `drop` increments as defined above.
  - Both saturate at 2^`CNT_W`−1.
  - `cnt_clear` zeroes all counters and takes precedence over a same-cycle increment; that increment is lost.
- **Readout**: `cnt_trg`/`cnt_drop` are a combinational mux on `cnt_idx`; an out-of-range index reads 0.
- **Reset**: `dst_data`=0, `dt`=0, counters=0, active matrix=0. Consequently `cnt_trg` and `cnt_drop` read 0.

## Timing
- `dst_data` is registered, with one-slot latency: inputs sampled on the `clk` edge with `sync`=1 appear after that edge. The value is held for the whole slot until the next `sync`=1 edge, then replaced (zero if no command).
- A `sel_load` in the same cycle as a `sync`=1 edge does not take effect for that slot; the new matrix applies from the next slot.
- The `deadtime` input is sampled only when a TRG is accepted. Changing it mid-deadtime does not alter the running count.
- Reset deasserted with `sync`=1: the first slot is evaluated on the next `sync`=1 edge after reset is released.

## Structure
- **Package `trigger_pkg`**: bit indices SYN=0, TRG=1, RSR=2, RST=3, CAL=4, the command width (5), and the priority-resolve function. The existing trigger logic shares these.
- **Sub-module `trigger_router_dst`**: one instance per sink, generated `NDST` times. It holds the priority resolve, the `dt` counter, the `trg`/`drop` counters and the output register.
- The top level holds the active matrix, the per-sink OR and the readout mux.

## Test plan
- **Reset routing**: apply reset, `sel_load` with sink 0 ← source 2, drive TRG on source 2 for one slot → `dst_data`[1] (sink 0 TRG) high for exactly the next slot; `cnt_trg`(0)=1.
- **Collision**: source 0 RST and source 1 TRG both routed to sink 1 in the same slot → sink 1 outputs RST only; `cnt_drop`(1)=1, `cnt_trg`(1)=0.
- **Deadtime**: `deadtime`=3, TRG every slot for 8 slots → accepted in slots 0 and 4 only; `cnt_trg`=2, `cnt_drop`=6. Repeat with an RST in slot 2 → next TRG accepted in slot 3.
- **Saturation**: `CNT_W`=4, 20 routed TRGs with `deadtime`=0 → `cnt_trg`=15. Assert `cnt_clear` concurrently with a TRG → counter reads 0.
- **Matrix update**: change `sel` without `sel_load` → routing unchanged; pulse `sel_load` on a `sync` edge → new routing from the following slot.
- **Reset mid-deadtime**: assert reset while `dt`=2 → `dst_data`=0 and `dt` cleared. After release and re-routing, TRG is accepted in the first evaluated slot.

Source files
------------

// File: rtl/trigger_pkg.sv
// Shared trigger command encoding and the single-command priority resolver
// used by the trigger routing logic.
package trigger_pkg;

   localparam int CMD_W = 5;
   localparam int SYN   = 0;
   localparam int TRG   = 1;
   localparam int RSR   = 2;
   localparam int RST   = 3;
   localparam int CAL   = 4;

   // One-hot of the highest-priority command: RST > RSR > CAL > TRG > SYN.
   function automatic logic [CMD_W-1:0] resolve_cmd(input logic [CMD_W-1:0] raw);
      resolve_cmd = '0;
      if (raw[RST])      resolve_cmd[RST] = 1'b1;
      else if (raw[RSR]) resolve_cmd[RSR] = 1'b1;
      else if (raw[CAL]) resolve_cmd[CAL] = 1'b1;
      else if (raw[TRG]) resolve_cmd[TRG] = 1'b1;
      else if (raw[SYN]) resolve_cmd[SYN] = 1'b1;
   endfunction

   function automatic logic [2:0] cmd_popcount(input logic [CMD_W-1:0] raw);
      cmd_popcount = '0;
      for (int i = 0; i < CMD_W; i++) begin
         cmd_popcount = cmd_popcount + 3'(raw[i]);
      end
   endfunction

endpackage

// File: rtl/trigger_router_dst.sv
// One trigger sink: priority resolve, TRG deadtime, registered command output
// and saturating accepted/dropped counters. State advances only on sync.
module trigger_router_dst
   import trigger_pkg::*;
#(
   parameter int DT_W  = 8,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sync,
   input  logic [CMD_W-1:0] raw,
   input  logic [DT_W-1:0]  deadtime,
   input  logic             cnt_clear,
   output logic [CMD_W-1:0] dst,
   output logic [CNT_W-1:0] cnt_trg,
   output logic [CNT_W-1:0] cnt_drop
);

   localparam int SUM_W = CNT_W + 1;

   logic [CMD_W-1:0] win;
   logic [CMD_W-1:0] cmd_nxt;
   logic             trg_block;
   logic             trg_inc;
   logic [2:0]       drop_inc;
   logic [DT_W-1:0]  dt;
   logic [DT_W-1:0]  dt_nxt;
   logic [SUM_W-1:0] trg_sum;
   logic [SUM_W-1:0] drop_sum;
   logic [CNT_W-1:0] trg_sat;
   logic [CNT_W-1:0] drop_sat;

   always_comb begin
      win       = resolve_cmd(raw);
      trg_block = win[TRG] && (dt != '0);
      trg_inc   = win[TRG] && !trg_block;
      // A blocked TRG leaves the slot empty; lower-priority SYN is not promoted.
      cmd_nxt   = trg_block ? '0 : win;
      drop_inc  = (raw != '0) ? (cmd_popcount(raw) - 3'd1) : 3'd0;
      drop_inc  = drop_inc + 3'(trg_block);

      dt_nxt = dt;
      if (win[RST] || win[RSR]) dt_nxt = '0;
      else if (trg_inc)         dt_nxt = deadtime;
      else if (dt != '0)        dt_nxt = dt - 1'b1;

      trg_sum  = {1'b0, cnt_trg}  + SUM_W'(trg_inc);
      drop_sum = {1'b0, cnt_drop} + SUM_W'(drop_inc);
      trg_sat  = trg_sum[CNT_W]  ? '1 : trg_sum[CNT_W-1:0];
      drop_sat = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         dst      <= '0;
         dt       <= '0;
         cnt_trg  <= '0;
         cnt_drop <= '0;
      end else begin
         if (sync) begin
            dst <= cmd_nxt;
            dt  <= dt_nxt;
         end
         if (cnt_clear) begin
            cnt_trg  <= '0;
            cnt_drop <= '0;
         end else if (sync) begin
            cnt_trg  <= trg_sat;
            cnt_drop <= drop_sat;
         end
      end
   end

endmodule

// File: rtl/trigger_router.sv
// Routes NSRC trigger sources to NDST sinks through a loadable routing matrix,
// with per-sink resolve/deadtime and a counter readout mux.
module trigger_router
   import trigger_pkg::*;
#(
   parameter int  NSRC  = 5,
   parameter int  NDST  = 3,
   parameter int  DT_W  = 8,
   parameter int  CNT_W = 32,
   localparam int IDX_W = (NDST > 1) ? $clog2(NDST) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sync,
   input  logic [NSRC*CMD_W-1:0]  src_data,
   input  logic [NDST*NSRC-1:0]   sel,
   input  logic                   sel_load,
   input  logic [DT_W-1:0]        deadtime,
   input  logic                   cnt_clear,
   input  logic [IDX_W-1:0]       cnt_idx,
   output logic [NDST*CMD_W-1:0]  dst_data,
   output logic [CNT_W-1:0]       cnt_trg,
   output logic [CNT_W-1:0]       cnt_drop
);

   logic [NDST*NSRC-1:0] sel_act;
   logic [CMD_W-1:0]     raw     [NDST];
   logic [CNT_W-1:0]     trg_arr [NDST];
   logic [CNT_W-1:0]     drop_arr[NDST];

   // Loading is not gated by sync; a load coinciding with a slot edge
   // only affects the following slot since raw uses the pre-load matrix.
   always_ff @(posedge clk) begin
      if (!reset)        sel_act <= '0;
      else if (sel_load) sel_act <= sel;
   end

   always_comb begin
      for (int d = 0; d < NDST; d++) begin
         raw[d] = '0;
         for (int s = 0; s < NSRC; s++) begin
            raw[d] = raw[d] | (src_data[s*CMD_W +: CMD_W] & {CMD_W{sel_act[d*NSRC+s]}});
         end
      end
   end

   for (genvar g = 0; g < NDST; g++) begin : g_dst
      trigger_router_dst #(
         .DT_W  (DT_W),
         .CNT_W (CNT_W)
      ) u_dst (
         .clk       (clk),
         .reset     (reset),
         .sync      (sync),
         .raw       (raw[g]),
         .deadtime  (deadtime),
         .cnt_clear (cnt_clear),
         .dst       (dst_data[g*CMD_W +: CMD_W]),
         .cnt_trg   (trg_arr[g]),
         .cnt_drop  (drop_arr[g])
      );
   end

   always_comb begin
      cnt_trg  = '0;
      cnt_drop = '0;
      for (int d = 0; d < NDST; d++) begin
         if (cnt_idx == IDX_W'(d)) begin
            cnt_trg  = trg_arr[d];
            cnt_drop = drop_arr[d];
         end
      end
   end

endmodule

// File: tb/tb_trigger_router.sv
// Scoreboard bench for trigger_router: stimulus queues expected sink words,
// a monitor compares dst_data every cycle against the current slot's value.
module tb_trigger_router;

   localparam int NSRC  = 5;
   localparam int NDST  = 3;
   localparam int DT_W  = 8;
   localparam int CNT_W = 4;

   logic                 clk;
   logic                 reset;
   logic                 sync;
   logic [NSRC*5-1:0]    src_data;
   logic [NDST*NSRC-1:0] sel;
   logic                 sel_load;
   logic [DT_W-1:0]      deadtime;
   logic                 cnt_clear;
   logic [1:0]           cnt_idx;
   logic [NDST*5-1:0]    dst_data;
   logic [CNT_W-1:0]     cnt_trg;
   logic [CNT_W-1:0]     cnt_drop;

   int checks = 0;
   int errors = 0;
   logic [NDST*5-1:0] exp_q[$];
   logic [NDST*5-1:0] cur_exp = '0;

   trigger_router #(
      .NSRC (NSRC), .NDST (NDST), .DT_W (DT_W), .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .sync      (sync),
      .src_data  (src_data),
      .sel       (sel),
      .sel_load  (sel_load),
      .deadtime  (deadtime),
      .cnt_clear (cnt_clear),
      .cnt_idx   (cnt_idx),
      .dst_data  (dst_data),
      .cnt_trg   (cnt_trg),
      .cnt_drop  (cnt_drop)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [NSRC*5-1:0] sb(input int s, input int c);
      sb = '0;
      sb[s*5+c] = 1'b1;
   endfunction

   function automatic logic [NDST*5-1:0] db(input int d, input int c);
      db = '0;
      db[d*5+c] = 1'b1;
   endfunction

   function automatic logic [NDST*NSRC-1:0] mb(input int d, input int s);
      mb = '0;
      mb[d*NSRC+s] = 1'b1;
   endfunction

   // Monitor: a sync edge presents a new sink word; between edges it must hold.
   always begin
      logic s_smp, r_smp;
      @(posedge clk);
      s_smp = sync;
      r_smp = reset;
      #1;
      if (!r_smp) begin
         cur_exp = '0;
      end else begin
         if (s_smp) begin
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL dst_unexpected_slot actual=%h (no expected entry)", dst_data);
            end else begin
               cur_exp = exp_q.pop_front();
            end
         end
         checks++;
         if (dst_data !== cur_exp) begin
            errors++;
            $display("FAIL dst_data t=%0t actual=%h required=%h", $time, dst_data, cur_exp);
         end
      end
   end

   task automatic slot(input logic [NSRC*5-1:0] src, input logic [NDST*5-1:0] exp);
      src_data = src;
      sync     = 1'b1;
      exp_q.push_back(exp);
      @(negedge clk);
      sync     = 1'b0;
      src_data = '0;
      @(negedge clk);
   endtask

   task automatic load(input logic [NDST*NSRC-1:0] m);
      sel      = m;
      sel_load = 1'b1;
      @(negedge clk);
      sel_load = 1'b0;
   endtask

   task automatic clear_cnt();
      cnt_clear = 1'b1;
      @(negedge clk);
      cnt_clear = 1'b0;
   endtask

   task automatic chk_cnt(input int idx, input int et, input int ed, input string name);
      cnt_idx = 2'(idx);
      #1;
      checks++;
      if (cnt_trg !== CNT_W'(et)) begin
         errors++;
         $display("FAIL %s cnt_trg[%0d] actual=%0d required=%0d", name, idx, cnt_trg, et);
      end
      checks++;
      if (cnt_drop !== CNT_W'(ed)) begin
         errors++;
         $display("FAIL %s cnt_drop[%0d] actual=%0d required=%0d", name, idx, cnt_drop, ed);
      end
   endtask

   initial begin
      reset = 1'b0; sync = 1'b0; src_data = '0; sel = '0; sel_load = 1'b0;
      deadtime = '0; cnt_clear = 1'b0; cnt_idx = '0;
      repeat (3) @(negedge clk);
      chk_cnt(0, 0, 0, "reset");
      checks++;
      if (dst_data !== '0) begin
         errors++;
         $display("FAIL reset_dst actual=%h required=0", dst_data);
      end
      reset = 1'b1;
      @(negedge clk);

      // Routing sink0 <- src2, single TRG
      load(mb(0, 2));
      slot(sb(2, 1), db(0, 1));
      slot('0, '0);
      chk_cnt(0, 1, 0, "route");

      // Collision on sink1: src0 RST + src1 TRG
      load(mb(0, 2) | mb(1, 0) | mb(1, 1));
      slot(sb(0, 3) | sb(1, 1), db(1, 3));
      chk_cnt(1, 0, 1, "collision");

      // Deadtime 3, TRG every slot
      deadtime = 8'd3;
      clear_cnt();
      chk_cnt(0, 0, 0, "clear");
      for (int i = 0; i < 8; i++)
         slot(sb(2, 1), (i == 0 || i == 4) ? db(0, 1) : '0);
      chk_cnt(0, 2, 6, "deadtime");

      // Same with RST joining the TRG in slot 2
      clear_cnt();
      for (int i = 0; i < 8; i++) begin
         if (i == 2)                           slot(sb(2, 1) | sb(2, 3), db(0, 3));
         else if (i == 0 || i == 3 || i == 7)  slot(sb(2, 1), db(0, 1));
         else                                  slot(sb(2, 1), '0);
      end
      chk_cnt(0, 3, 5, "deadtime_rst");

      // Saturation on sink1 with deadtime disabled
      deadtime = 8'd0;
      clear_cnt();
      for (int i = 0; i < 20; i++) slot(sb(1, 1), db(1, 1));
      chk_cnt(1, 15, 0, "saturate");
      cnt_clear = 1'b1;
      slot(sb(1, 1), db(1, 1));
      cnt_clear = 1'b0;
      chk_cnt(1, 0, 0, "clear_vs_inc");

      // Matrix update: sel alone has no effect, load on a sync edge applies next slot
      sel = mb(2, 1);
      slot(sb(1, 1), db(1, 1));
      sel_load = 1'b1;
      src_data = sb(1, 1);
      sync     = 1'b1;
      exp_q.push_back(db(1, 1));
      @(negedge clk);
      sel_load = 1'b0; sync = 1'b0; src_data = '0;
      @(negedge clk);
      slot(sb(1, 1), db(2, 1));
      chk_cnt(1, 2, 0, "matrix_old");
      chk_cnt(2, 1, 0, "matrix_new");
      chk_cnt(3, 0, 0, "idx_range");

      // Reset while sink0 deadtime is at 2
      load(mb(0, 2));
      deadtime = 8'd3;
      slot(sb(2, 1), db(0, 1));
      slot('0, '0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (dst_data !== '0) begin
         errors++;
         $display("FAIL reset_mid_dt_dst actual=%h required=0", dst_data);
      end
      chk_cnt(0, 0, 0, "reset_mid_dt");
      reset = 1'b1;
      @(negedge clk);
      load(mb(0, 2));
      slot(sb(2, 1), db(0, 1));
      slot('0, '0);
      chk_cnt(0, 1, 0, "post_reset_trg");

      for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain actual=%0d pending required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
